// File: rtl/alu.sv
// ============================================================================
// Module   : alu
// Purpose  : 64-bit Y86 execute-stage ALU (add/sub/and/xor), registered result
//            and flags; zero/sign flag registers built only with ALU_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  control,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] ans,
  output logic        overflow,
  output logic        zero,
  output logic        sign
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  logic        is_sub;
  logic [63:0] b_eff;
  logic [63:0] sum;
  logic        sum_ovf;
  logic [63:0] result;
  logic        result_ovf;

  // Subtraction reuses the adder: a + ~b + 1, carry-out dropped.
  assign is_sub  = (control == OP_SUB);
  assign b_eff   = is_sub ? ~b : b;
  assign sum     = a + b_eff + {63'd0, is_sub};
  assign sum_ovf = (a[63] == b_eff[63]) && (sum[63] != a[63]);

  always_comb begin
    result     = sum;
    result_ovf = 1'b0;
    case (control)
      OP_ADD,
      OP_SUB: begin
        result     = sum;
        result_ovf = sum_ovf;
      end
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      default: result = sum;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ans      <= 64'd0;
      overflow <= 1'b0;
    end else begin
      ans      <= result;
      overflow <= result_ovf;
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero <= 1'b0;
      sign <= 1'b0;
    end else begin
      zero <= (result == 64'd0);
      sign <= result[63];
    end
  end
`else
  assign zero = 1'b0;
  assign sign = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases plus randomized traffic
// compared every cycle against a wide-arithmetic reference model.
`default_nettype none

module tb_alu;

`ifdef ALU_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  localparam logic [63:0] MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  control;
  logic [63:0] a, b;
  logic [63:0] ans;
  logic        overflow, zero, sign;

  int checks = 0;
  int errors = 0;

  alu dut (
    .clk      (clk),
    .rst      (rst),
    .control  (control),
    .a        (a),
    .b        (b),
    .ans      (ans),
    .overflow (overflow),
    .zero     (zero),
    .sign     (sign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact signed result in 65 bits; overflow when it does not fit in 64.
  function automatic void model(input logic [1:0] c, input logic [63:0] x, input logic [63:0] y,
                                output logic [63:0] r, output logic o);
    logic signed [64:0] wide;
    wide = '0;
    o    = 1'b0;
    case (c)
      2'b00: wide = $signed({x[63], x}) + $signed({y[63], y});
      2'b01: wide = $signed({x[63], x}) - $signed({y[63], y});
      default: ;
    endcase
    case (c)
      2'b00, 2'b01: begin
        r = wide[63:0];
        o = (wide[64] != wide[63]);
      end
      2'b10:   r = x & y;
      default: r = x ^ y;
    endcase
  endfunction

  // Per-cycle compare against the model for whatever was sampled at this edge.
  always @(posedge clk) begin
    logic [63:0] er;
    logic        eo;
    logic        live;
    live = !rst;
    model(control, a, b, er, eo);
    #1;
    if (live && !rst) begin
      chk("model_ans", ans, er);
      chk("model_ovf", {63'd0, overflow}, {63'd0, eo});
      chk("model_zero", {63'd0, zero}, {63'd0, FLAGS && (er == 64'd0)});
      chk("model_sign", {63'd0, sign}, {63'd0, FLAGS && er[63]});
    end
  end

  task automatic directed(input string name, input logic [1:0] c, input logic [63:0] x,
                          input logic [63:0] y, input logic [63:0] e_ans, input logic e_ovf,
                          input logic e_zero, input logic e_sign);
    @(negedge clk);
    control = c;
    a       = x;
    b       = y;
    @(posedge clk);
    #1;
    chk({name, "_ans"}, ans, e_ans);
    chk({name, "_ovf"}, {63'd0, overflow}, {63'd0, e_ovf});
    chk({name, "_zero"}, {63'd0, zero}, {63'd0, FLAGS && e_zero});
    chk({name, "_sign"}, {63'd0, sign}, {63'd0, FLAGS && e_sign});
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return MAX;
      3:       return MIN;
      4:       return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] mr;
    logic        mo;

    // Pin the model to hand-computed values.
    model(2'b00, MAX, MAX, mr, mo);
    chk("pin_add_ans", mr, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("pin_add_ovf", {63'd0, mo}, 64'd1);
    model(2'b01, MIN, MAX, mr, mo);
    chk("pin_sub_ans", mr, 64'd1);
    chk("pin_sub_ovf", {63'd0, mo}, 64'd1);

    rst     = 1'b1;
    control = 2'b00;
    a       = 64'd5;
    b       = 64'd5;
    #2;
    chk("rst_ans", ans, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd0);
    chk("rst_sign", {63'd0, sign}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_after_rst", ans, 64'd10);

    directed("sub_max_max", 2'b01, MAX, MAX, 64'd0, 1'b0, 1'b1, 1'b0);
    directed("sub_min_min", 2'b01, MIN, MIN, 64'd0, 1'b0, 1'b1, 1'b0);
    directed("sub_max_min", 2'b01, MAX, MIN, '1, 1'b1, 1'b0, 1'b1);
    directed("sub_min_max", 2'b01, MIN, MAX, 64'd1, 1'b1, 1'b0, 1'b0);
    directed("add_max_max", 2'b00, MAX, MAX, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1);
    directed("add_min_min", 2'b00, MIN, MIN, 64'd0, 1'b1, 1'b1, 1'b0);
    directed("and_pat", 2'b10, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
             64'hF000_F000_F000_F000, 1'b0, 1'b0, 1'b1);
    directed("xor_pat", 2'b11, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
             64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 1'b0, 1'b0);

    // Back-to-back random traffic, checked every cycle by the compare process.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      control = 2'($urandom_range(0, 3));
      a       = pick();
      b       = pick();
    end

    // Reset mid-stream clears outputs without a clock edge.
    directed("pre_rst", 2'b00, MAX, MAX, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    control = 2'b01;
    a       = 64'd3;
    b       = 64'd9;
    rst     = 1'b1;
    #1;
    chk("mid_rst_ans", ans, 64'd0);
    chk("mid_rst_ovf", {63'd0, overflow}, 64'd0);
    chk("mid_rst_zero", {63'd0, zero}, 64'd0);
    chk("mid_rst_sign", {63'd0, sign}, 64'd0);
    @(posedge clk);
    #1;
    chk("held_rst_ans", ans, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    directed("post_rst", 2'b01, 64'd3, 64'd9, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b0, 1'b1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
